// File: rtl/reservation_station_pkg.sv
// Shared reservation-station / ALU definitions: opcodes, tag and CDB widths.
// Feature macro honoured by the RS: RS_DISPATCH_BYPASS_EN.
package reservation_station_pkg;

    localparam int XLEN      = 32;
    localparam int OPC_W     = 6;
    localparam int ROB_W     = 4;
    localparam int CDB_TAG_W = ROB_W;
    localparam int CDB_VAL_W = XLEN;

    typedef logic [XLEN-1:0]  word_t;
    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t OP_ADD   = 6'd0;
    localparam opcode_t OP_SUB   = 6'd1;
    localparam opcode_t OP_AND   = 6'd2;
    localparam opcode_t OP_OR    = 6'd3;
    localparam opcode_t OP_XOR   = 6'd4;
    localparam opcode_t OP_SLL   = 6'd5;
    localparam opcode_t OP_SRL   = 6'd6;
    localparam opcode_t OP_SRA   = 6'd7;
    localparam opcode_t OP_SLT   = 6'd8;
    localparam opcode_t OP_SLTU  = 6'd9;
    localparam opcode_t OP_LUI   = 6'd10;
    localparam opcode_t OP_AUIPC = 6'd11;
    localparam opcode_t OP_JAL   = 6'd12;
    localparam opcode_t OP_JALR  = 6'd13;
    localparam opcode_t OP_BEQ   = 6'd14;
    localparam opcode_t OP_BNE   = 6'd15;

endpackage

// File: rtl/reservation_station_select.sv
// rs_select: lowest-index priority encoders for the reservation station
// (first free slot and first issuable entry), each with a found flag.
module rs_select
    import reservation_station_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     busy,
    input  logic [N-1:0]     issuable,
    output logic [IDX_W-1:0] free_idx,
    output logic             free_found,
    output logic [IDX_W-1:0] iss_idx,
    output logic             iss_found
);

    // Scan high to low so the lowest matching index wins.
    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        iss_idx    = '0;
        iss_found  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_idx   = IDX_W'(i);
                free_found = 1'b1;
            end
            if (issuable[i]) begin
                iss_idx   = IDX_W'(i);
                iss_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: holds dispatched ops, wakes operands from two CDBs
// and issues the lowest ready entry to the ALU. Option: RS_DISPATCH_BYPASS_EN.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int RS_SIZE = 8,
    parameter int ROB_W   = reservation_station_pkg::ROB_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [ROB_W-1:0] in_rob_id,
    input  logic [OPC_W-1:0] in_opcode,
    input  logic [XLEN-1:0]  in_vj,
    input  logic [XLEN-1:0]  in_vk,
    input  logic [ROB_W-1:0] in_qj,
    input  logic [ROB_W-1:0] in_qk,
    input  logic             in_rj,
    input  logic             in_rk,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  in_pc,
    output logic             full,
    input  logic             cdb0_valid,
    input  logic [ROB_W-1:0] cdb0_rob_id,
    input  logic [XLEN-1:0]  cdb0_val,
    input  logic             cdb1_valid,
    input  logic [ROB_W-1:0] cdb1_rob_id,
    input  logic [XLEN-1:0]  cdb1_val,
    output logic             alu_en,
    output logic [ROB_W-1:0] alu_rob_id,
    output logic [OPC_W-1:0] alu_opcode,
    output logic [XLEN-1:0]  alu_rs1,
    output logic [XLEN-1:0]  alu_rs2,
    output logic [XLEN-1:0]  alu_imm,
    output logic [XLEN-1:0]  alu_pc
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] rj;
    logic [RS_SIZE-1:0] rk;
    logic [OPC_W-1:0]   opcode [RS_SIZE];
    logic [ROB_W-1:0]   rob_id [RS_SIZE];
    logic [ROB_W-1:0]   qj     [RS_SIZE];
    logic [ROB_W-1:0]   qk     [RS_SIZE];
    logic [XLEN-1:0]    vj     [RS_SIZE];
    logic [XLEN-1:0]    vk     [RS_SIZE];
    logic [XLEN-1:0]    imm    [RS_SIZE];
    logic [XLEN-1:0]    pc     [RS_SIZE];

    logic [RS_SIZE-1:0] issuable;
    logic [IDX_W-1:0]   free_idx;
    logic               free_found;
    logic [IDX_W-1:0]   iss_idx;
    logic               iss_found;

    logic [XLEN-1:0]    d_vj;
    logic [XLEN-1:0]    d_vk;
    logic               d_rj;
    logic               d_rk;
    logic               dispatch;
    logic               byp_take;
    logic               write_en;

    assign issuable = busy & rj & rk;

    rs_select #(
        .N     (RS_SIZE),
        .IDX_W (IDX_W)
    ) u_select (
        .busy       (busy),
        .issuable   (issuable),
        .free_idx   (free_idx),
        .free_found (free_found),
        .iss_idx    (iss_idx),
        .iss_found  (iss_found)
    );

    assign full     = !free_found;
    assign dispatch = in_valid && !full;

    // Capture same-cycle CDB results for not-ready incoming operands.
    always_comb begin
        d_vj = in_vj;
        d_rj = in_rj;
        d_vk = in_vk;
        d_rk = in_rk;
        if (!in_rj && cdb0_valid && cdb0_rob_id == in_qj) begin
            d_vj = cdb0_val;
            d_rj = 1'b1;
        end else if (!in_rj && cdb1_valid && cdb1_rob_id == in_qj) begin
            d_vj = cdb1_val;
            d_rj = 1'b1;
        end
        if (!in_rk && cdb0_valid && cdb0_rob_id == in_qk) begin
            d_vk = cdb0_val;
            d_rk = 1'b1;
        end else if (!in_rk && cdb1_valid && cdb1_rob_id == in_qk) begin
            d_vk = cdb1_val;
            d_rk = 1'b1;
        end
    end

`ifdef RS_DISPATCH_BYPASS_EN
    assign byp_take = dispatch && d_rj && d_rk && !iss_found;
`else
    assign byp_take = 1'b0;
`endif

    assign write_en = dispatch && !byp_take;

    // Entry state: wakeup from CDBs, issue release, dispatch allocation.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else if (rdy) begin
            if (clear) begin
                busy <= '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy[i] && !rj[i]) begin
                        if (cdb0_valid && cdb0_rob_id == qj[i]) begin
                            vj[i] <= cdb0_val;
                            rj[i] <= 1'b1;
                        end else if (cdb1_valid && cdb1_rob_id == qj[i]) begin
                            vj[i] <= cdb1_val;
                            rj[i] <= 1'b1;
                        end
                    end
                    if (busy[i] && !rk[i]) begin
                        if (cdb0_valid && cdb0_rob_id == qk[i]) begin
                            vk[i] <= cdb0_val;
                            rk[i] <= 1'b1;
                        end else if (cdb1_valid && cdb1_rob_id == qk[i]) begin
                            vk[i] <= cdb1_val;
                            rk[i] <= 1'b1;
                        end
                    end
                end
                if (iss_found) begin
                    busy[iss_idx] <= 1'b0;
                end
                if (write_en) begin
                    busy[free_idx]   <= 1'b1;
                    opcode[free_idx] <= in_opcode;
                    rob_id[free_idx] <= in_rob_id;
                    qj[free_idx]     <= in_qj;
                    qk[free_idx]     <= in_qk;
                    vj[free_idx]     <= d_vj;
                    vk[free_idx]     <= d_vk;
                    rj[free_idx]     <= d_rj;
                    rk[free_idx]     <= d_rk;
                    imm[free_idx]    <= in_imm;
                    pc[free_idx]     <= in_pc;
                end
            end
        end
    end

    // Registered ALU issue port; stored entries beat a bypassed dispatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_en     <= 1'b0;
            alu_rob_id <= '0;
            alu_opcode <= '0;
            alu_rs1    <= '0;
            alu_rs2    <= '0;
            alu_imm    <= '0;
            alu_pc     <= '0;
        end else if (rdy) begin
            if (clear) begin
                alu_en <= 1'b0;
            end else if (iss_found) begin
                alu_en     <= 1'b1;
                alu_rob_id <= rob_id[iss_idx];
                alu_opcode <= opcode[iss_idx];
                alu_rs1    <= vj[iss_idx];
                alu_rs2    <= vk[iss_idx];
                alu_imm    <= imm[iss_idx];
                alu_pc     <= pc[iss_idx];
            end else if (byp_take) begin
                alu_en     <= 1'b1;
                alu_rob_id <= in_rob_id;
                alu_opcode <= in_opcode;
                alu_rs1    <= d_vj;
                alu_rs2    <= d_vk;
                alu_imm    <= in_imm;
                alu_pc     <= in_pc;
            end else begin
                alu_en <= 1'b0;
            end
        end
    end

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 Parameter RS_SIZE, default 8: number of entries, a power of two.
REQ-002 Parameter ROB_W, default 4: ROB tag width.
REQ-003 clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-004 rdy  in  1  global enable; clear  in  1  mispredict flush.
REQ-005 in_valid  in  1  dispatch request; in_rob_id  in  ROB_W  destination tag; in_opcode  in  6  internal opcode.
REQ-006 in_vj, in_vk  in  32  operand values; in_qj, in_qk  in  ROB_W  producer tags; in_rj, in_rk  in  1  operand-ready flags.
REQ-007 in_imm, in_pc  in  32  immediate and instruction PC; full  out  1  no free entry.
REQ-008 cdb0_valid/cdb0_rob_id/cdb0_val  in  1/ROB_W/32  ALU broadcast; cdb1_valid/cdb1_rob_id/cdb1_val  in  1/ROB_W/32  load-store broadcast.
REQ-009 alu_en  out  1  issue strobe; alu_rob_id  out  ROB_W; alu_opcode  out  6; alu_rs1, alu_rs2, alu_imm, alu_pc  out  32.

Function
REQ-010 Each entry SHALL hold: busy, opcode, rob_id, vj, vk, qj, qk, rj, rk, imm, pc.
REQ-011 full SHALL be combinational and high exactly when all RS_SIZE entries are busy; in_valid while full SHALL be ignored.
REQ-012 A dispatch SHALL write the lowest-index non-busy entry, sampled when rdy is high.
REQ-013 At dispatch, a not-ready operand whose tag matches a same-cycle valid CDB broadcast SHALL be captured as ready with the CDB value.
REQ-014 Each busy entry SHALL compare qj/qk with both CDBs every cycle; on match it SHALL load the value and set the ready flag; cdb0 SHALL take priority if both match.
REQ-015 An entry is issuable when busy, rj and rk are high; the lowest-index issuable entry SHALL be selected.
REQ-016 Issue SHALL register alu_en=1 with the entry fields (vj->alu_rs1, vk->alu_rs2) and clear its busy bit at the same edge; alu_en=0 when nothing is issuable.
REQ-017 Latency: dispatch with both operands ready in cycle N SHALL give alu_en=1 in cycle N+2; CDB wakeup in cycle N SHALL give issue no earlier than cycle N+2.
REQ-018 At most one issue and one dispatch per cycle; a slot freed by issue SHALL NOT be reused by the same-cycle dispatch.
REQ-019 rdy low SHALL freeze all state and outputs, including alu_en.
REQ-020 clear high (with rdy) SHALL invalidate all entries and drive alu_en=0 next cycle, overriding a same-cycle dispatch and issue.

Reset
REQ-021 rst SHALL clear all busy bits, set alu_en=0, and zero alu_rob_id, alu_opcode, alu_rs1, alu_rs2, alu_imm and alu_pc; full SHALL read 0 after reset.
REQ-022 rst SHALL take priority over rdy and clear; entry payload fields need not be reset.

Configuration
REQ-023 With RS_DISPATCH_BYPASS_EN defined, an incoming dispatch with both operands ready (after REQ-013 capture) SHALL be eligible for selection that cycle, at lower priority than stored entries; when selected it SHALL NOT occupy an entry, and alu_en SHALL rise in cycle N+1.
REQ-024 Without RS_DISPATCH_BYPASS_EN, every dispatch SHALL be written to an entry and the REQ-017 latency SHALL apply.

Structure
REQ-025 Opcode constants (OP_*), ROB_W and the CDB field widths SHALL live in the shared macros package alongside the ALU definitions.
REQ-026 One sub-module, rs_select, SHALL implement the priority encoders (free-slot find, issuable find) returning index and found flag.

Verification
REQ-027 Dispatch ADD, rj=rk=1, vj=5, vk=7, rob 3 in cycle 0 -> alu_en=1, rob 3, rs1=5, rs2=7 in cycle 2 (cycle 1 with bypass).
REQ-028 Dispatch with rj=0, qj=2; cdb1 broadcasts rob 2, val 0x10 in cycle 4 -> issue with rs1=0x10 in cycle 6.
REQ-029 Dispatch rk=0, qk=6 while cdb0 broadcasts rob 6, val 9 in the same cycle -> entry ready, issues with rs2=9.
REQ-030 Fill 8 non-ready entries -> full=1; ninth in_valid ignored; one wakeup and issue -> full=0 the cycle after issue.
REQ-031 Three busy entries, then clear -> alu_en=0 next cycle, full=0, later CDB broadcasts produce no issue.
REQ-032 Hold rdy=0 for 3 cycles with a ready entry -> outputs frozen; issue resumes after rdy returns high.
